fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the unicycle/pipelined PISA core. Holds the program counter and drives the combinational instruction memory's `address` input. Registers the returned 20-bit instruction into the IF/ID pipeline register for the decoder. Handles start/halt sequencing, decode stalls and branch/jump redirects.

## Interface
- `DATA_WIDTH`, 20: instruction width; matches instruction memory.
- `ADDRESS_WIDTH`, 8: PC and memory address width.
- `RESET_PC`, 0: PC value after reset.
- `COUNT_WIDTH`, 16: width of the fetched-instruction counter.

Clock and reset: one clock; reset is asynchronous and active-high.

- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  leave IDLE and begin fetching.
- `halt`  in  1  from decode/control: stop fetching permanently until reset.
- `stall`  in  1  from hazard unit: hold PC and IF/ID.
- `redirect_valid`  in  1  taken branch/jump from execute.
- `redirect_target`  in  ADDRESS_WIDTH  new PC.
- `imem_address`  out  ADDRESS_WIDTH  to instruction memory `address`.
- `imem_instruction`  in  DATA_WIDTH  from instruction memory `instruction`, same cycle.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `ifid_instruction`  out  DATA_WIDTH  registered instruction.
- `ifid_pc`  out  ADDRESS_WIDTH  address it was fetched from.
- `ifid_pc_next`  out  ADDRESS_WIDTH  `ifid_pc + 1`, modulo 2^ADDRESS_WIDTH.
- `running`  out  1  high while the FSM is in F_RUN.
- `fetch_count`  out  COUNT_WIDTH  number of valid IF/ID captures; saturates at all-ones.

## Operation
- **FSM states:** F_IDLE, F_RUN, F_HALTED.
- **Reset values:**
  - state = F_IDLE, pc = RESET_PC.
  - `ifid_valid` = 0; `ifid_instruction`, `ifid_pc`, `ifid_pc_next` = 0.
  - `fetch_count` = 0, `running` = 0.
- `imem_address` = pc register, always. It has no combinational path from any input.
- **F_IDLE:**
  - PC holds and `ifid_valid` = 0.
  - `start` = 1 → F_RUN at the next edge. The PC is not advanced on that edge.
- **F_RUN:** at each edge, the first matching rule applies.
  1. `halt` = 1: go to F_HALTED; `ifid_valid` <= 0; PC holds.
  2. `redirect_valid` = 1: pc <= `redirect_target`; `ifid_valid` <= 0 (squash the wrong-path fetch). Redirect overrides `stall`.
  3. `stall` = 1: PC and all IF/ID fields hold, including `ifid_valid`.
  4. Otherwise: pc <= pc + 1 (wraps 2^ADDRESS_WIDTH−1 → 0). IF/ID <= {1, `imem_instruction`, pc, pc+1}. `fetch_count` increments unless saturated.
- **F_HALTED:**
  - PC holds and `ifid_valid` = 0.
  - `start`, `stall` and redirect are ignored. Only `rst` leaves this state.
- **Ignored inputs:** `halt` and `redirect_valid` are ignored in F_IDLE.
- **Reset mid-operation:** all state returns to reset values immediately, regardless of `stall` or `redirect_valid`.
- **Unknown instructions:** an X instruction from out-of-range memory is captured as-is. This block does no checking.

## Timing
- One-cycle fetch latency: the instruction at pc appears in IF/ID after the next rising edge.
- `start` sampled at edge N → first capture (pc = RESET_PC) at edge N+1.
- A redirect sampled at edge N produces a bubble in IF/ID after N. Target instruction is captured at N+1.
- Stall holds for exactly the cycles it is high; no extra bubble on release.
- `running` is a decode of the registered state.

## Structure
- **Package `fetch_pkg`:**
  - `fetch_state_t` enum (F_IDLE, F_RUN, F_HALTED).
  - `ifid_t` struct (valid, instruction, pc, pc_next), parameterised widths via package localparams DATA_WIDTH = 20, ADDRESS_WIDTH = 8.
- **Sub-module `program_counter`:** PC register with load (redirect), hold (stall/idle/halt) and increment controls. FSM, IF/ID register and counter live in `fetch_stage`.

## Test plan
- **Reset then start:** `rst` pulse, `start` at edge 2, memory[0..2] = 0x12345, 0xABCDE, 0x00001 → IF/ID after edges 3, 4, 5 is {1, 0x12345, 0, 1}, {1, 0xABCDE, 1, 2}, {1, 0x00001, 2, 3}; `fetch_count` = 3.
- **Stall:** 2-cycle stall while IF/ID holds pc = 4 → IF/ID and `imem_address` = 5 frozen for 2 edges; pc = 5 captured on the first edge after release; no bubble.
- **Redirect with simultaneous stall:** `redirect_valid` = 1, target = 0x40, `stall` = 1 → `ifid_valid` = 0 after that edge; next capture is {1, mem[0x40], 0x40, 0x41}.
- **Wrap-around:** redirect to 0xFF, then free-run → captures pc 0xFF with `ifid_pc_next` = 0x00, then pc 0x00.
- **Halt:** `halt` together with `redirect_valid` → F_HALTED, `ifid_valid` = 0, `running` = 0, PC unchanged; `start` ignored afterwards; `rst` returns to F_IDLE, pc = 0.
- **Async reset mid-run:** `rst` asserted between edges during a stall → outputs reach reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage.
//   fetch_state_t : fetch sequencing FSM states
//   ifid_t        : IF/ID pipeline register payload as seen by the decoder
package fetch_pkg;

   localparam int unsigned DATA_WIDTH    = 20;
   localparam int unsigned ADDRESS_WIDTH = 8;

   typedef enum logic [1:0] {
      F_IDLE   = 2'd0,
      F_RUN    = 2'd1,
      F_HALTED = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic                     valid;
      logic [DATA_WIDTH-1:0]    instruction;
      logic [ADDRESS_WIDTH-1:0] pc;
      logic [ADDRESS_WIDTH-1:0] pc_next;
   } ifid_t;

endpackage : fetch_pkg

// File: rtl/program_counter.sv
// Program counter register with load, hold and increment controls.
//   clk, rst       : clock, asynchronous active-high reset
//   load_i         : load target_i (redirect); has priority over inc_i
//   target_i       : redirect target address
//   inc_i          : advance by one, wrapping modulo 2^ADDRESS_WIDTH
//   pc_o           : registered program counter
//   pc_plus1_c_o   : combinational pc_o + 1 (wrapping)
// Holding is the default when neither load_i nor inc_i is asserted.
module program_counter #(
   parameter int unsigned              ADDRESS_WIDTH = 8,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_i,
   input  logic [ADDRESS_WIDTH-1:0] target_i,
   input  logic                     inc_i,
   output logic [ADDRESS_WIDTH-1:0] pc_o,
   output logic [ADDRESS_WIDTH-1:0] pc_plus1_c_o
);

   logic [ADDRESS_WIDTH-1:0] pc_q;
   logic [ADDRESS_WIDTH-1:0] pc_d;

   // Natural overflow of the add gives the required wrap to zero.
   assign pc_plus1_c_o = pc_q + ADDRESS_WIDTH'(1);

   // Next-PC selection.
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = target_i;
      end else if (inc_i) begin
         pc_d = pc_plus1_c_o;
      end
   end

   // PC register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule : program_counter

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and registers the returned word into IF/ID.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : leave idle and begin fetching
//   halt              : stop fetching until reset
//   stall             : hold PC and IF/ID
//   redirect_valid    : taken branch/jump, load redirect_target into PC
//   redirect_target   : new PC
//   imem_address      : instruction memory address (the PC register)
//   imem_instruction  : instruction memory read data, same cycle
//   ifid_valid        : IF/ID holds a real instruction
//   ifid_instruction  : registered instruction
//   ifid_pc           : address the instruction was fetched from
//   ifid_pc_next      : ifid_pc + 1, wrapping
//   running           : FSM is in F_RUN
//   fetch_count       : number of valid IF/ID captures, saturating
module fetch_stage #(
   parameter int unsigned              DATA_WIDTH    = 20,
   parameter int unsigned              ADDRESS_WIDTH = 8,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
   parameter int unsigned              COUNT_WIDTH   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     halt,
   input  logic                     stall,
   input  logic                     redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0] redirect_target,
   output logic [ADDRESS_WIDTH-1:0] imem_address,
   input  logic [DATA_WIDTH-1:0]    imem_instruction,
   output logic                     ifid_valid,
   output logic [DATA_WIDTH-1:0]    ifid_instruction,
   output logic [ADDRESS_WIDTH-1:0] ifid_pc,
   output logic [ADDRESS_WIDTH-1:0] ifid_pc_next,
   output logic                     running,
   output logic [COUNT_WIDTH-1:0]   fetch_count
);

   import fetch_pkg::*;

   fetch_state_t state_q, state_d;

   logic                     ifid_valid_q, ifid_valid_d;
   logic [DATA_WIDTH-1:0]    ifid_instr_q, ifid_instr_d;
   logic [ADDRESS_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
   logic [ADDRESS_WIDTH-1:0] ifid_pc_next_q, ifid_pc_next_d;
   logic [COUNT_WIDTH-1:0]   count_q, count_d;

   logic                     pc_load_c;
   logic                     pc_inc_c;
   logic [ADDRESS_WIDTH-1:0] pc;
   logic [ADDRESS_WIDTH-1:0] pc_plus1_c;

   program_counter #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .RESET_PC      (RESET_PC)
   ) u_pc (
      .clk          (clk),
      .rst          (rst),
      .load_i       (pc_load_c),
      .target_i     (redirect_target),
      .inc_i        (pc_inc_c),
      .pc_o         (pc),
      .pc_plus1_c_o (pc_plus1_c)
   );

   // Next-state, PC control and IF/ID update; first matching rule wins in F_RUN.
   always_comb begin
      state_d        = state_q;
      pc_load_c      = 1'b0;
      pc_inc_c       = 1'b0;
      ifid_valid_d   = ifid_valid_q;
      ifid_instr_d   = ifid_instr_q;
      ifid_pc_d      = ifid_pc_q;
      ifid_pc_next_d = ifid_pc_next_q;
      count_d        = count_q;

      case (state_q)
         F_IDLE: begin
            ifid_valid_d = 1'b0;
            // PC is deliberately not advanced on the start edge.
            if (start) begin
               state_d = F_RUN;
            end
         end

         F_RUN: begin
            if (halt) begin
               state_d      = F_HALTED;
               ifid_valid_d = 1'b0;
            end else if (redirect_valid) begin
               // Squash the wrong-path word fetched this cycle.
               pc_load_c    = 1'b1;
               ifid_valid_d = 1'b0;
            end else if (!stall) begin
               pc_inc_c       = 1'b1;
               ifid_valid_d   = 1'b1;
               ifid_instr_d   = imem_instruction;
               ifid_pc_d      = pc;
               ifid_pc_next_d = pc_plus1_c;
               if (count_q != {COUNT_WIDTH{1'b1}}) begin
                  count_d = count_q + COUNT_WIDTH'(1);
               end
            end
         end

         F_HALTED: begin
            ifid_valid_d = 1'b0;
         end

         default: begin
            state_d      = F_IDLE;
            ifid_valid_d = 1'b0;
         end
      endcase
   end

   // State, IF/ID and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= F_IDLE;
         ifid_valid_q   <= 1'b0;
         ifid_instr_q   <= '0;
         ifid_pc_q      <= '0;
         ifid_pc_next_q <= '0;
         count_q        <= '0;
      end else begin
         state_q        <= state_d;
         ifid_valid_q   <= ifid_valid_d;
         ifid_instr_q   <= ifid_instr_d;
         ifid_pc_q      <= ifid_pc_d;
         ifid_pc_next_q <= ifid_pc_next_d;
         count_q        <= count_d;
      end
   end

   assign imem_address     = pc;
   assign ifid_valid       = ifid_valid_q;
   assign ifid_instruction = ifid_instr_q;
   assign ifid_pc          = ifid_pc_q;
   assign ifid_pc_next     = ifid_pc_next_q;
   assign fetch_count      = count_q;
   assign running          = (state_q == F_RUN);

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the stimulus process pushes expected
// IF/ID captures; a negedge monitor pops and compares each new capture.
module tb_fetch_stage;

   localparam int unsigned DW = 20;
   localparam int unsigned AW = 8;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          halt;
   logic          stall;
   logic          redirect_valid;
   logic [AW-1:0] redirect_target;
   logic [AW-1:0] imem_address;
   logic [DW-1:0] imem_instruction;
   logic          ifid_valid;
   logic [DW-1:0] ifid_instruction;
   logic [AW-1:0] ifid_pc;
   logic [AW-1:0] ifid_pc_next;
   logic          running;
   logic [CW-1:0] fetch_count;

   always #5 clk = ~clk;

   fetch_stage #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .RESET_PC      (8'h00),
      .COUNT_WIDTH   (CW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .halt             (halt),
      .stall            (stall),
      .redirect_valid   (redirect_valid),
      .redirect_target  (redirect_target),
      .imem_address     (imem_address),
      .imem_instruction (imem_instruction),
      .ifid_valid       (ifid_valid),
      .ifid_instruction (ifid_instruction),
      .ifid_pc          (ifid_pc),
      .ifid_pc_next     (ifid_pc_next),
      .running          (running),
      .fetch_count      (fetch_count)
   );

   // Combinational instruction memory.
   logic [DW-1:0] mem [0:255];
   assign imem_instruction = mem[imem_address];

   typedef struct packed {
      logic [DW-1:0] instr;
      logic [AW-1:0] pc;
      logic [AW-1:0] pc_next;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [DW-1:0] instr, input logic [AW-1:0] pc, input logic [AW-1:0] pc_next);
      exp_t e;
      e.instr   = instr;
      e.pc      = pc;
      e.pc_next = pc_next;
      sb_q.push_back(e);
   endtask

   // A valid IF/ID after an edge where stall was low is a fresh capture.
   logic stall_prev;
   always @(posedge clk or posedge rst) begin
      if (rst) stall_prev <= 1'b1;
      else     stall_prev <= stall;
   end

   always @(negedge clk) begin
      if (!rst && ifid_valid === 1'b1 && !stall_prev) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_capture: got pc 0x%0h with empty scoreboard (t=%0t)", ifid_pc, $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("cap_instruction", 32'(ifid_instruction), 32'(e.instr));
            chk("cap_pc",          32'(ifid_pc),          32'(e.pc));
            chk("cap_pc_next",     32'(ifid_pc_next),     32'(e.pc_next));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {12'hC00, 8'(i)};
      mem[0] = 20'h12345;
      mem[1] = 20'hABCDE;
      mem[2] = 20'h00001;

      rst = 1'b1; start = 1'b0; halt = 1'b0; stall = 1'b0;
      redirect_valid = 1'b0; redirect_target = '0;
      #1;
      chk("rst_ifid_valid", 32'(ifid_valid), 32'h0);
      chk("rst_ifid_instr", 32'(ifid_instruction), 32'h0);
      chk("rst_ifid_pc", 32'(ifid_pc), 32'h0);
      chk("rst_ifid_pc_next", 32'(ifid_pc_next), 32'h0);
      chk("rst_count", 32'(fetch_count), 32'h0);
      chk("rst_running", 32'(running), 32'h0);
      chk("rst_imem_addr", 32'(imem_address), 32'h0);
      cyc();
      rst = 1'b0;

      // Start, then three sequential fetches.
      start = 1'b1;
      cyc();
      chk("start_running", 32'(running), 32'h1);
      chk("start_no_advance", 32'(imem_address), 32'h0);
      chk("start_no_capture", 32'(ifid_valid), 32'h0);
      start = 1'b0;
      push(20'h12345, 8'h00, 8'h01);
      push(20'hABCDE, 8'h01, 8'h02);
      push(20'h00001, 8'h02, 8'h03);
      repeat (3) cyc();
      chk("run_count3", 32'(fetch_count), 32'd3);
      chk("run_imem_addr3", 32'(imem_address), 32'h3);

      // Two-cycle stall while IF/ID holds pc 4.
      push(20'hC0003, 8'h03, 8'h04);
      push(20'hC0004, 8'h04, 8'h05);
      cyc(); cyc();
      stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cyc();
         chk("stall_ifid_pc", 32'(ifid_pc), 32'h4);
         chk("stall_ifid_valid", 32'(ifid_valid), 32'h1);
         chk("stall_imem_addr", 32'(imem_address), 32'h5);
      end
      stall = 1'b0;
      push(20'hC0005, 8'h05, 8'h06);
      cyc();
      chk("release_ifid_pc", 32'(ifid_pc), 32'h5);
      chk("release_count", 32'(fetch_count), 32'd6);

      // Redirect overrides simultaneous stall.
      redirect_valid = 1'b1; redirect_target = 8'h40; stall = 1'b1;
      cyc();
      chk("redir_bubble", 32'(ifid_valid), 32'h0);
      chk("redir_imem_addr", 32'(imem_address), 32'h40);
      chk("redir_count", 32'(fetch_count), 32'd6);
      redirect_valid = 1'b0; stall = 1'b0;
      push(20'hC0040, 8'h40, 8'h41);
      cyc();
      chk("redir_count7", 32'(fetch_count), 32'd7);

      // Wrap-around from 0xFF.
      redirect_valid = 1'b1; redirect_target = 8'hFF;
      cyc();
      chk("wrap_bubble", 32'(ifid_valid), 32'h0);
      redirect_valid = 1'b0;
      push(20'hC00FF, 8'hFF, 8'h00);
      push(20'h12345, 8'h00, 8'h01);
      cyc();
      chk("wrap_pc_next", 32'(ifid_pc_next), 32'h0);
      cyc();
      chk("wrap_imem_addr", 32'(imem_address), 32'h1);
      chk("wrap_count", 32'(fetch_count), 32'd9);

      // Halt wins over a simultaneous redirect; halted ignores everything.
      halt = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h80;
      cyc();
      chk("halt_running", 32'(running), 32'h0);
      chk("halt_valid", 32'(ifid_valid), 32'h0);
      chk("halt_pc_hold", 32'(imem_address), 32'h1);
      halt = 1'b0; redirect_valid = 1'b0; start = 1'b1;
      cyc();
      chk("halted_start_ignored", 32'(running), 32'h0);
      chk("halted_pc_hold", 32'(imem_address), 32'h1);
      start = 1'b0; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h22;
      cyc();
      chk("halted_redir_ignored", 32'(imem_address), 32'h1);
      chk("halted_count", 32'(fetch_count), 32'd9);
      stall = 1'b0; redirect_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("halt_rst_pc", 32'(imem_address), 32'h0);
      chk("halt_rst_count", 32'(fetch_count), 32'h0);
      cyc();
      rst = 1'b0;

      // Idle ignores halt and redirect.
      halt = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h33;
      cyc();
      chk("idle_running", 32'(running), 32'h0);
      chk("idle_pc_hold", 32'(imem_address), 32'h0);
      halt = 1'b0; redirect_valid = 1'b0; start = 1'b1;
      cyc();
      chk("restart_running", 32'(running), 32'h1);
      start = 1'b0;
      push(20'h12345, 8'h00, 8'h01);
      push(20'hABCDE, 8'h01, 8'h02);
      cyc(); cyc();
      chk("restart_count", 32'(fetch_count), 32'd2);

      // Asynchronous reset between edges during a stall with a pending redirect.
      stall = 1'b1;
      cyc();
      redirect_valid = 1'b1; redirect_target = 8'h50;
      #2;
      rst = 1'b1;
      #1;
      chk("async_valid", 32'(ifid_valid), 32'h0);
      chk("async_instr", 32'(ifid_instruction), 32'h0);
      chk("async_pc", 32'(ifid_pc), 32'h0);
      chk("async_pc_next", 32'(ifid_pc_next), 32'h0);
      chk("async_count", 32'(fetch_count), 32'h0);
      chk("async_running", 32'(running), 32'h0);
      chk("async_imem_addr", 32'(imem_address), 32'h0);
      stall = 1'b0; redirect_valid = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();

      chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fetch_stage
